// File: rtl/msu_result_normalizer_if.sv
// AXI-stream bundle shared by the MSU result input and the normalized output.
interface msu_result_normalizer_if #(
  parameter int AXI_LEN = 32
);
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic [AXI_LEN-1:0] tdata;
  logic [AXI_LEN/8-1:0] tkeep;

  modport master (output tvalid, tdata, tlast, tkeep, input tready);
  // Upstream carries no tkeep; the slave side only sees the fields it uses.
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/msu_result_normalizer.sv
// Collects a redundant-form MSU result frame, carry-propagates it word-serially
// into canonical form, and streams t_current + value + final carry back out.
module msu_result_normalizer #(
  parameter int AXI_LEN  = 32,
  parameter int T_LEN    = 64,
  parameter int WRD_BITS = 16,
  parameter int NUM_WRDS = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  msu_result_normalizer_if.slave    s_axis,
  msu_result_normalizer_if.master   m_axis,
  output logic                      frame_err
);
  localparam int DAT_BITS  = NUM_WRDS * WRD_BITS;
  localparam int RED_BITS  = NUM_WRDS * (WRD_BITS + 1);
  localparam int IN_BEATS  = (T_LEN + RED_BITS) / AXI_LEN;
  localparam int OUT_BEATS = (T_LEN + DAT_BITS) / AXI_LEN + 1;
  localparam int BUF_BITS  = IN_BEATS * AXI_LEN;
  localparam int OUT_BITS  = OUT_BEATS * AXI_LEN;
  localparam int RW        = WRD_BITS + 1;
  localparam int SW        = WRD_BITS + 2;
  localparam int ICW       = $clog2(IN_BEATS + 1);
  localparam int OCW       = $clog2(OUT_BEATS + 1);
  localparam int WCW       = $clog2(NUM_WRDS + 1);

  localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_BEATS);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BEATS - 1);
  localparam logic [WCW-1:0] WRD_LAST = WCW'(NUM_WRDS - 1);

  generate
    if ((T_LEN % AXI_LEN) != 0 || (DAT_BITS % AXI_LEN) != 0 ||
        (RED_BITS % AXI_LEN) != 0 || AXI_LEN < 2) begin : g_bad_params
      $error("msu_result_normalizer: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {RECV, NORM, SEND} state_e;

  // Assert asynchronously, release two clocks later so every flop leaves reset together.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e         state_q, state_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  logic           drop_q, drop_d;
  logic [WCW-1:0] widx_q, widx_d;
  logic [1:0]     cry_q, cry_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic           vld_q, vld_d;
  logic           err_q, err_d;

  logic [BUF_BITS-1:0] buf_q;
  logic [DAT_BITS-1:0] nrm_q;

  logic           s_rdy, s_acc, shift_in, norm_en;
  logic [ICW-1:0] in_nxt;
  logic [RW-1:0]  wrd;
  logic [SW-1:0]  sum;
  logic [OUT_BITS-1:0] out_vec;

  assign s_rdy  = (state_q == RECV) && rst_n;
  assign s_acc  = s_axis.tvalid && s_rdy;
  assign in_nxt = in_cnt_q + 1'b1;
  // The word under normalization always sits just above t_current.
  assign wrd    = buf_q[T_LEN +: RW];
  assign sum    = SW'(wrd) + SW'(cry_q);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    drop_d    = drop_q;
    widx_d    = widx_q;
    cry_d     = cry_q;
    out_cnt_d = out_cnt_q;
    vld_d     = vld_q;
    err_d     = err_q;
    shift_in  = 1'b0;
    norm_en   = 1'b0;
    case (state_q)
      RECV: begin
        if (s_acc) begin
          if (drop_q) begin
            // Overlong frame: swallow beats until its tlast shows up.
            in_cnt_d = '0;
            if (s_axis.tlast) drop_d = 1'b0;
          end else begin
            shift_in = 1'b1;
            if (in_nxt == IN_LAST) begin
              in_cnt_d = '0;
              if (s_axis.tlast) begin
                state_d = NORM;
                widx_d  = '0;
                cry_d   = '0;
              end else begin
                err_d  = 1'b1;
                drop_d = 1'b1;
              end
            end else if (s_axis.tlast) begin
              err_d    = 1'b1;
              in_cnt_d = '0;
            end else begin
              in_cnt_d = in_nxt;
            end
          end
        end
      end
      NORM: begin
        norm_en = 1'b1;
        cry_d   = sum[SW-1:WRD_BITS];
        widx_d  = widx_q + 1'b1;
        if (widx_q == WRD_LAST) begin
          state_d   = SEND;
          widx_d    = '0;
          out_cnt_d = '0;
        end
      end
      SEND: begin
        // One settling cycle before the first beat gives the NUM_WRDS+1 latency.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (m_axis.tready) begin
          if (out_cnt_q == OUT_LAST) begin
            state_d   = RECV;
            vld_d     = 1'b0;
            out_cnt_d = '0;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RECV;
      in_cnt_q  <= '0;
      drop_q    <= 1'b0;
      widx_q    <= '0;
      cry_q     <= '0;
      out_cnt_q <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      drop_q    <= drop_d;
      widx_q    <= widx_d;
      cry_q     <= cry_d;
      out_cnt_q <= out_cnt_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  // Datapath storage carries no reset; control decides when it is meaningful.
  always_ff @(posedge clk) begin
    if (shift_in)
      buf_q <= {s_axis.tdata, buf_q[BUF_BITS-1:AXI_LEN]};
    else if (norm_en)
      buf_q[BUF_BITS-1:T_LEN] <= {RW'(0), buf_q[BUF_BITS-1:T_LEN+RW]};
    if (norm_en)
      nrm_q <= {sum[WRD_BITS-1:0], nrm_q[DAT_BITS-1:WRD_BITS]};
  end

  assign out_vec = {(AXI_LEN-2)'(0), cry_q, nrm_q, buf_q[T_LEN-1:0]};

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tdata  = out_vec[int'(out_cnt_q) * AXI_LEN +: AXI_LEN];
  assign m_axis.tlast  = vld_q && (out_cnt_q == OUT_LAST);
  assign m_axis.tkeep  = '1;
  assign frame_err     = err_q;
endmodule

// File: tb/tb_msu_result_normalizer.sv
// Scoreboard bench: whole-number reference sum per frame, expected beats queued
// at stimulus time and popped on each output handshake.
module tb_msu_result_normalizer;
  localparam int AXI_LEN = 32;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic frame_err;

  msu_result_normalizer_if #(.AXI_LEN(AXI_LEN)) s_if ();
  msu_result_normalizer_if #(.AXI_LEN(AXI_LEN)) m_if ();

  msu_result_normalizer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   acc_cyc = 0, n_acc = 0, mon_beat = 0;
  bit   wait_first = 0, rnd_rdy = 0;
  logic [63:0] tcur;
  logic [16:0] wrd[64];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Output side: randomize tready, check latency and every accepted beat.
  initial begin
    exp_t e;
    m_if.tready = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) continue;
      m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wait_first && m_if.tvalid) begin
        chk("latency", 64'(cyc - acc_cyc), 64'd65);
        wait_first = 0;
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(m_if.tvalid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("data_b%0d", mon_beat), 64'(m_if.tdata), 64'(e.data));
          chk($sformatf("last_b%0d", mon_beat), 64'(m_if.tlast), 64'(e.last));
          chk("tkeep", 64'(m_if.tkeep), 64'hF);
          mon_beat = e.last ? 0 : mon_beat + 1;
        end
      end
    end
  end

  task automatic put_beat(input logic [31:0] d, input logic l, input bit gaps);
    int t = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = l;
    while (s_if.tready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("s_tready_timeout", 64'(s_if.tready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    n_acc++;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_if.tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic send_frame(input bit push, input bit gaps, input bit lat);
    logic [1151:0] fr;
    logic [1025:0] acc;
    logic [1119:0] ov;
    fr[63:0] = tcur;
    acc = '0;
    for (int i = 0; i < 64; i++) begin
      fr[64 + i*17 +: 17] = wrd[i];
      acc = acc + (1026'(wrd[i]) << (16*i));
    end
    ov = {30'b0, acc[1025:1024], acc[1023:0], tcur};
    if (push)
      for (int k = 0; k < 35; k++) exp_q.push_back('{ov[k*32 +: 32], k == 34});
    for (int k = 0; k < 36; k++) put_beat(fr[k*32 +: 32], k == 35, gaps);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (lat) wait_first = 1;
  endtask

  task automatic rand_frame();
    tcur = {$urandom, $urandom};
    for (int i = 0; i < 64; i++) wrd[i] = 17'($urandom_range(0, 17'h1FFFF));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_tvalid"}, 64'(m_if.tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_if.tlast), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    exp_q.delete();
    wait_first = 0;
    @(negedge clk);
    reset_n = 1'b1;
    mon_beat = 0;
    repeat (3) @(negedge clk);
    chk({tag, "_s_tready"}, 64'(s_if.tready), 64'd1);
  endtask

  initial begin
    int t;
    reset_n     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tkeep  = '1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(s_if.tready), 64'd1);

    // All-ones words with a redundant top bit in word 0: the ripple leaves
    // 0xFFFF in the low half-word, zeros above, and a final carry of 1.
    tcur = 64'd5;
    for (int i = 0; i < 64; i++) wrd[i] = 17'h0FFFF;
    wrd[0] = 17'h1FFFF;
    send_frame(1, 0, 1);

    tcur = 64'h1_0000_0003;
    for (int i = 0; i < 64; i++) wrd[i] = 17'h00001;
    send_frame(1, 0, 1);

    rnd_rdy = 1;
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      send_frame(1, 1, 1);
    end
    drain();
    rnd_rdy = 0;

    // Early tlast on beat 10.
    for (int k = 1; k <= 10; k++) put_beat($urandom, k == 10, 0);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (80) @(negedge clk);
    chk("early_frame_err", 64'(frame_err), 64'd1);
    chk("early_no_out", 64'(m_if.tvalid), 64'd0);
    rand_frame();
    send_frame(1, 0, 1);
    drain();

    // Reset while normalizing.
    rand_frame();
    send_frame(0, 0, 0);
    repeat (20) @(negedge clk);
    pulse_reset("rst_norm");

    // Overlong frame: 40 beats, tlast only on the last.
    n_acc = 0;
    for (int k = 1; k <= 40; k++) put_beat($urandom, k == 40, 0);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    chk("long_accepted", 64'(n_acc), 64'd40);
    repeat (80) @(negedge clk);
    chk("long_frame_err", 64'(frame_err), 64'd1);
    chk("long_no_out", 64'(m_if.tvalid), 64'd0);
    rand_frame();
    send_frame(1, 0, 1);
    drain();

    // Reset during output beat 12.
    rand_frame();
    send_frame(1, 0, 0);
    t = 0;
    while (mon_beat < 12 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("send_reached_b12", 64'(mon_beat >= 12), 64'd1);
    pulse_reset("rst_send");

    rand_frame();
    send_frame(1, 0, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
